ysyx_23060203_ifetch: RTL and testbench

Instruction fetch stage of the single-issue RV32 core. It owns the architectural PC and issues one instruction read at a time over a valid/ready request and valid response memory port. It hands each fetched {pc, inst} pair to the decode stage through a valid/ready handshake, and it accepts PC redirects (dnpc) from the execute stage. It replaces the bare PC register plus combinational instruction-memory lookup with a latency-tolerant, flushable fetch path.

---
 rtl/ysyx_23060203_ifetch.sv | 84 ++++++++
 tb/tb_ysyx_23060203_ifetch.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_23060203_ifetch.sv
// ysyx_23060203_ifetch: flushable single-outstanding instruction fetch stage
module ysyx_23060203_ifetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
    state_t      state;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fault;
    logic        drop;
    logic [31:0] target;

    assign target        = redirect_pc & ~32'h3;
    assign mem_req_valid = state == REQ;
    assign mem_req_addr  = pc;
    assign out_valid     = state == OUT;
    assign out_pc        = pc;
    assign out_inst      = inst;
    assign out_fault     = fault;

    // fetch FSM: drop marks an in-flight response made stale by a redirect
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
            pc    <= RESET_PC;
            inst  <= '0;
            fault <= 1'b0;
            drop  <= 1'b0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (redirect_valid) pc <= target;
                    if (mem_req_ready) begin
                        state <= WAIT;
                        drop  <= redirect_valid;
                    end
                end
                WAIT: begin
                    if (mem_rsp_valid) begin
                        drop <= 1'b0;
                        if (drop || redirect_valid) begin
                            state <= REQ;
                            if (redirect_valid) pc <= target;
                        end else begin
                            inst  <= mem_rsp_err ? '0 : mem_rsp_data;
                            fault <= mem_rsp_err;
                            state <= OUT;
                        end
                    end else if (redirect_valid) begin
                        pc   <= target;
                        drop <= 1'b1;
                    end
                end
                OUT: begin
                    if (redirect_valid) begin
                        pc    <= target;
                        state <= REQ;
                    end else if (out_ready) begin
                        pc    <= pc + 32'd4;
                        state <= REQ;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ysyx_23060203_ifetch.sv
// tb_ysyx_23060203_ifetch: directed scoreboard bench for the fetch stage
module tb_ysyx_23060203_ifetch;
    localparam logic [31:0] RST = 32'h8000_0000;
    localparam logic [31:0] KEY = 32'h5A5A_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        fault;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        mem_req_valid;
    logic        mem_req_ready = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = '0;
    logic        mem_rsp_err = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_fault;

    exp_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          hs = 0;
    int          h0 = 0;
    int          delay = 1;
    int          cnt = 0;
    int          xfers = 0;
    int          last_xfer = 0;
    int          gap = 0;
    bit          pend = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] last_hs = '0;
    logic [31:0] err_addr = 32'h8000_0010;

    ysyx_23060203_ifetch dut (
        .clk(clk), .rstn(rstn),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .mem_rsp_err(mem_rsp_err),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_fault(out_fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] a, input logic f);
        exp_t e;
        e.pc = a;
        e.inst = f ? 32'h0 : (a ^ KEY);
        e.fault = f;
        q.push_back(e);
    endtask

    // one cycle: memory model, input drive and scoreboard check at the falling edge
    task automatic step(input bit rdy, input bit ordy, input bit rv, input logic [31:0] rpc);
        exp_t e;
        @(negedge clk);
        cyc++;
        mem_rsp_valid = 1'b0;
        mem_rsp_data = '0;
        mem_rsp_err = 1'b0;
        if (pend) begin
            cnt--;
            if (cnt == 0) begin
                pend = 1'b0;
                mem_rsp_valid = 1'b1;
                mem_rsp_data = pend_addr ^ KEY;
                mem_rsp_err = pend_addr == err_addr;
            end
        end
        mem_req_ready = rdy;
        out_ready = ordy;
        redirect_valid = rv;
        redirect_pc = rpc;
        if (rstn && mem_req_valid && rdy) begin
            hs++;
            last_hs = mem_req_addr;
            pend_addr = mem_req_addr;
            pend = 1'b1;
            cnt = delay;
        end
        if (rstn && out_valid && ordy) begin
            n_cmp++;
            assert (q.size() > 0) else begin
                n_err++;
                $error("FAIL spurious_out: observed pc %h expected no transfer", out_pc);
            end
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out_pc", out_pc, e.pc);
                chk("out_inst", out_inst, e.inst);
                chk("out_fault", {31'b0, out_fault}, {31'b0, e.fault});
            end
            gap = cyc - last_xfer;
            last_xfer = cyc;
            xfers++;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0, '0);
    endtask

    task automatic chk_reset();
        chk("rst_req_valid", {31'b0, mem_req_valid}, 32'h0);
        chk("rst_req_addr", mem_req_addr, RST);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_out_pc", out_pc, RST);
        chk("rst_out_inst", out_inst, 32'h0);
        chk("rst_out_fault", {31'b0, out_fault}, 32'h0);
    endtask

    initial begin
        run(2);
        chk_reset();
        push(RST, 1'b0);
        push(RST + 32'd4, 1'b0);
        push(RST + 32'd8, 1'b0);
        rstn = 1'b1;
        run(1);
        chk("first_req_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("first_req_addr", mem_req_addr, RST);
        run(5);
        chk("gap_1", gap, 3);
        run(3);
        chk("gap_2", gap, 3);
        push(RST + 32'h0C, 1'b0);
        run(2);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b0, '0);
            chk("stall_valid", {31'b0, out_valid}, 32'h1);
            chk("stall_pc", out_pc, RST + 32'h0C);
            chk("stall_inst", out_inst, (RST + 32'h0C) ^ KEY);
            chk("stall_no_req", {31'b0, mem_req_valid}, 32'h0);
        end
        push(err_addr, 1'b1);
        run(1);
        run(1);
        chk("after_stall_addr", mem_req_addr, RST + 32'h10);
        run(2);
        delay = 3;
        run(1);
        chk("after_fault_addr", mem_req_addr, RST + 32'h14);
        step(1'b1, 1'b1, 1'b1, 32'h8000_0102);
        chk("wait_redir_nov", {31'b0, out_valid}, 32'h0);
        run(1);
        chk("stale_nov_1", {31'b0, out_valid}, 32'h0);
        run(1);
        chk("stale_nov_2", {31'b0, out_valid}, 32'h0);
        delay = 1;
        push(32'h8000_0100, 1'b0);
        run(1);
        chk("redir_addr", mem_req_addr, 32'h8000_0100);
        chk("stale_nov_3", {31'b0, out_valid}, 32'h0);
        run(2);
        h0 = hs;
        step(1'b0, 1'b1, 1'b0, '0);
        chk("busy_addr", mem_req_addr, 32'h8000_0104);
        step(1'b0, 1'b1, 1'b1, 32'h8000_0040);
        step(1'b0, 1'b1, 1'b0, '0);
        chk("busy_redir_addr", mem_req_addr, 32'h8000_0040);
        chk("busy_redir_valid", {31'b0, mem_req_valid}, 32'h1);
        step(1'b0, 1'b1, 1'b0, '0);
        push(32'h8000_0040, 1'b0);
        run(1);
        chk("busy_hs_count", hs - h0, 1);
        chk("busy_hs_addr", last_hs, 32'h8000_0040);
        run(2);
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("hs_redir_addr", last_hs, 32'h8000_0044);
        run(1);
        push(32'hFFFF_FFFC, 1'b0);
        run(1);
        chk("wrap_req_addr", mem_req_addr, 32'hFFFF_FFFC);
        run(2);
        run(1);
        chk("wrap_next_addr", mem_req_addr, 32'h0);
        chk("wrap_next_valid", {31'b0, mem_req_valid}, 32'h1);
        run(1);
        chk("mid_wait_nov", {31'b0, out_valid}, 32'h0);
        rstn = 1'b0;
        #1;
        chk_reset();
        run(1);
        rstn = 1'b1;
        push(RST, 1'b0);
        run(1);
        chk("restart_valid", {31'b0, mem_req_valid}, 32'h1);
        chk("restart_addr", mem_req_addr, RST);
        run(4);
        chk("queue_drained", 32'(q.size()), 32'h0);
        chk("xfer_count", xfers, 9);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
